// File: rtl/mem_arb_pkg.sv
// Shared types and sizing helpers for the unified-memory port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_D,
      OWN_I,
      OWN_X
   } owner_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE
   } state_t;

   // Width needed to hold values 0..max_val, never less than one bit.
   function automatic int cnt_w(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/arb_pick.sv
// Fixed-priority requester selector (d > x > i) with a starvation override for x.
module arb_pick
   import mem_arb_pkg::*;
(
   input  logic   d_elig,
   input  logic   i_elig,
   input  logic   x_elig,
   input  logic   starve_hit,
   output owner_t winner
);

   always_comb begin
      winner = OWN_NONE;
      if (x_elig && starve_hit) begin
         winner = OWN_X;
      end else if (d_elig) begin
         winner = OWN_D;
      end else if (x_elig) begin
         winner = OWN_X;
      end else if (i_elig) begin
         winner = OWN_I;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port unified memory between MEM stage, fetch and an external master,
// running each access through a fixed-latency issue/wait/complete sequence.
//
// state | meaning
// IDLE  | arbitrate eligible requesters, latch the winner's command
// ISSUE | mem_en strobe for one cycle, load latency counter
// WAIT  | count down remaining memory latency
// DONE  | mem_rdata valid, pulse the owner's done, then return to IDLE
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst_n,

   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_done,
   output logic              stall_mem,

   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              i_flush,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_done,
   output logic              stall_if,

   input  logic              x_req,
   input  logic              x_we,
   input  logic [ADDR_W-1:0] x_addr,
   input  logic [DATA_W-1:0] x_wdata,
   output logic [DATA_W-1:0] x_rdata,
   output logic              x_done,

   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int WCNT_W = cnt_w(MEM_LAT);
   localparam int SCNT_W = cnt_w(STARVE_MAX);
   localparam logic [WCNT_W-1:0] LAT_LOAD   = WCNT_W'(MEM_LAT - 1);
   localparam logic [WCNT_W-1:0] WCNT_ONE   = WCNT_W'(1);
   localparam logic [SCNT_W-1:0] STARVE_LIM = SCNT_W'(STARVE_MAX);
   localparam logic [SCNT_W-1:0] SCNT_ONE   = SCNT_W'(1);

   state_t            state;
   owner_t            owner;
   owner_t            winner;
   logic [WCNT_W-1:0] wait_cnt;
   logic [SCNT_W-1:0] starve_cnt;
   logic              flush_seen;
   logic              i_elig;
   logic              starve_hit;
   logic              in_done;
   logic [DATA_W-1:0] d_rdata_q;
   logic [DATA_W-1:0] i_rdata_q;
   logic [DATA_W-1:0] x_rdata_q;

   assign i_elig     = i_req & ~i_flush;
   assign starve_hit = (starve_cnt == STARVE_LIM);

   arb_pick u_pick (
      .d_elig     (d_req),
      .i_elig     (i_elig),
      .x_elig     (x_req),
      .starve_hit (starve_hit),
      .winner     (winner)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         owner      <= OWN_NONE;
         wait_cnt   <= '0;
         flush_seen <= 1'b0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         d_rdata_q  <= '0;
         i_rdata_q  <= '0;
         x_rdata_q  <= '0;
      end else begin
         mem_en <= 1'b0;
         case (state)
            IDLE: begin
               flush_seen <= 1'b0;
               if (winner != OWN_NONE) begin
                  owner  <= winner;
                  mem_en <= 1'b1;
                  state  <= ISSUE;
                  if (winner == OWN_D) begin
                     mem_we    <= d_we;
                     mem_addr  <= d_addr;
                     mem_wdata <= d_wdata;
                  end else if (winner == OWN_X) begin
                     mem_we    <= x_we;
                     mem_addr  <= x_addr;
                     mem_wdata <= x_wdata;
                  end else begin
                     mem_we    <= 1'b0;
                     mem_addr  <= i_addr;
                     mem_wdata <= '0;
                  end
               end
            end
            ISSUE: begin
               wait_cnt <= LAT_LOAD;
               if (owner == OWN_I && i_flush) begin
                  flush_seen <= 1'b1;
               end
               state <= (MEM_LAT == 1) ? DONE : WAIT;
            end
            WAIT: begin
               if (owner == OWN_I && i_flush) begin
                  flush_seen <= 1'b1;
               end
               if (wait_cnt <= WCNT_ONE) begin
                  state <= DONE;
               end else begin
                  wait_cnt <= wait_cnt - WCNT_ONE;
               end
            end
            DONE: begin
               if (owner == OWN_D) d_rdata_q <= mem_rdata;
               if (owner == OWN_I) i_rdata_q <= mem_rdata;
               if (owner == OWN_X) x_rdata_q <= mem_rdata;
               owner      <= OWN_NONE;
               flush_seen <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Only arbitrations that x actually loses count toward its override.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= '0;
      end else if (!x_req) begin
         starve_cnt <= '0;
      end else if (state == IDLE && winner != OWN_NONE) begin
         if (winner == OWN_X) begin
            starve_cnt <= '0;
         end else if (starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + SCNT_ONE;
         end
      end
   end

   assign in_done = (state == DONE);

   // A flush arriving in the DONE cycle itself must still kill the fetch completion.
   assign d_done = in_done && (owner == OWN_D);
   assign x_done = in_done && (owner == OWN_X);
   assign i_done = in_done && (owner == OWN_I) && !flush_seen && !i_flush;

   assign d_rdata = d_done ? mem_rdata : d_rdata_q;
   assign x_rdata = x_done ? mem_rdata : x_rdata_q;
   assign i_rdata = (in_done && owner == OWN_I) ? mem_rdata : i_rdata_q;

   assign stall_mem = rst_n & d_req & ~d_done;
   assign stall_if  = rst_n & i_req & ~i_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with MEM_LAT=2, STARVE_MAX=3 and a behavioural memory.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int LAT  = 2;
   localparam int SMAX = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          d_req, d_we, i_req, i_flush, x_req, x_we;
   logic [AW-1:0] d_addr, i_addr, x_addr;
   logic [DW-1:0] d_wdata, x_wdata;
   logic [DW-1:0] d_rdata, i_rdata, x_rdata;
   logic          d_done, i_done, x_done, stall_mem, stall_if;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
      .clk(clk), .rst_n(rst_n),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_done(d_done), .stall_mem(stall_mem),
      .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
      .i_rdata(i_rdata), .i_done(i_done), .stall_if(stall_if),
      .x_req(x_req), .x_we(x_we), .x_addr(x_addr), .x_wdata(x_wdata),
      .x_rdata(x_rdata), .x_done(x_done),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   typedef struct {
      int          cyc;
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
      bit          chk_data;
      int          who;
   } exp_t;

   exp_t cmd_q[$];
   exp_t done_q[$];
   int   n_vec  = 0;
   int   n_miss = 0;
   int   cyc    = 0;
   int   base;

   logic [31:0] mem_model [logic [31:0]];
   logic [31:0] rd_pipe = '0;

   always @(posedge clk) cyc++;

   // Two-cycle read latency: mem_en seen at edge t, data presented after edge t+1.
   always @(posedge clk) begin
      mem_rdata <= rd_pipe;
      rd_pipe   <= 32'h0;
      if (mem_en) begin
         if (mem_we) begin
            mem_model[mem_addr] = mem_wdata;
            rd_pipe <= 32'h0;
         end else begin
            rd_pipe <= mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'h0;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic exp_cmd(input int c, input logic we, input logic [31:0] a, input logic [31:0] wd);
      cmd_q.push_back('{cyc: c, we: we, addr: a, data: wd, chk_data: 1'b0, who: 0});
   endtask

   task automatic exp_done(input int c, input int who, input logic [31:0] rd, input bit chkd);
      done_q.push_back('{cyc: c, we: 1'b0, addr: 32'h0, data: rd, chk_data: chkd, who: who});
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   exp_t        me;
   int          nd, who;
   logic [31:0] rd;

   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_en) begin
            if (cmd_q.size() == 0) begin
               n_vec++;
               n_miss++;
               $display("FAIL cmd_unexpected: mem_en=1 addr %h at cycle %0d, none expected", mem_addr, cyc);
            end else begin
               me = cmd_q.pop_front();
               chk("cmd_cycle", cyc, me.cyc);
               chk("cmd_we", {31'b0, mem_we}, {31'b0, me.we});
               chk("cmd_addr", mem_addr, me.addr);
               if (me.we) chk("cmd_wdata", mem_wdata, me.data);
            end
         end
         nd = int'(d_done) + int'(i_done) + int'(x_done);
         if (nd > 0) begin
            who = d_done ? 1 : (i_done ? 2 : 3);
            rd  = d_done ? d_rdata : (i_done ? i_rdata : x_rdata);
            if (done_q.size() == 0) begin
               n_vec++;
               n_miss++;
               $display("FAIL done_unexpected: requester %0d done at cycle %0d, none expected", who, cyc);
            end else begin
               me = done_q.pop_front();
               chk("done_count", nd, 1);
               chk("done_who", who, me.who);
               chk("done_cycle", cyc, me.cyc);
               if (me.chk_data) chk("done_rdata", rd, me.data);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
      i_req = 0; i_addr = '0; i_flush = 0;
      x_req = 0; x_we = 0; x_addr = '0; x_wdata = '0;
      mem_model[32'h40]  = 32'hDEAD_BEEF;
      mem_model[32'h10]  = 32'h1111_1111;
      mem_model[32'h20]  = 32'h2222_2222;
      mem_model[32'h30]  = 32'h3333_3333;
      mem_model[32'h44]  = 32'h4444_4444;
      mem_model[32'h200] = 32'h0BAD_F00D;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_mem_en", {31'b0, mem_en}, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_d_done", {31'b0, d_done}, 0);
      chk("rst_x_rdata", x_rdata, 0);
      chk("rst_state", 32'(dut.state), 32'(IDLE));
      @(negedge clk) rst_n = 1'b1;
      next_cyc();
      next_cyc();

      // single MEM-stage load
      base = cyc;
      d_req = 1; d_we = 0; d_addr = 32'h40;
      exp_cmd(base + 1, 1'b0, 32'h40, 32'h0);
      exp_done(base + 3, 1, 32'hDEAD_BEEF, 1'b1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("t1_stall_mem", {31'b0, stall_mem}, (k < 3) ? 1 : 0);
         if (d_done) d_req = 0;
         next_cyc();
      end

      // three-way contention, each requester drops after its own done
      base = cyc;
      d_req = 1; d_addr = 32'h10; d_wdata = 32'hA;
      x_req = 1; x_addr = 32'h20; x_we = 0; x_wdata = 32'hB;
      i_req = 1; i_addr = 32'h30;
      exp_cmd(base + 1, 1'b0, 32'h10, 32'h0);
      exp_done(base + 3, 1, 32'h1111_1111, 1'b1);
      exp_cmd(base + 5, 1'b0, 32'h20, 32'h0);
      exp_done(base + 7, 3, 32'h2222_2222, 1'b1);
      exp_cmd(base + 9, 1'b0, 32'h30, 32'h0);
      exp_done(base + 11, 2, 32'h3333_3333, 1'b1);
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         chk("t2_stall_if", {31'b0, stall_if}, (k < 11) ? 1 : 0);
         if (d_done) d_req = 0;
         if (x_done) x_req = 0;
         if (i_done) i_req = 0;
         next_cyc();
      end

      // starvation: d held, x held; x wins the 4th arbitration, counter then restarts
      base = cyc;
      d_req = 1; d_addr = 32'h44;
      x_req = 1; x_addr = 32'h200; x_we = 0;
      exp_cmd(base + 1, 1'b0, 32'h44, 32'h0);
      exp_done(base + 3, 1, 32'h4444_4444, 1'b1);
      exp_cmd(base + 5, 1'b0, 32'h44, 32'h0);
      exp_done(base + 7, 1, 32'h4444_4444, 1'b1);
      exp_cmd(base + 9, 1'b0, 32'h44, 32'h0);
      exp_done(base + 11, 1, 32'h4444_4444, 1'b1);
      exp_cmd(base + 13, 1'b0, 32'h200, 32'h0);
      exp_done(base + 15, 3, 32'h0BAD_F00D, 1'b1);
      exp_cmd(base + 17, 1'b0, 32'h44, 32'h0);
      exp_done(base + 19, 1, 32'h4444_4444, 1'b1);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (k == 19) begin
            d_req = 0;
            x_req = 0;
         end
         next_cyc();
      end

      // fetch flushed while waiting on memory
      base = cyc;
      i_req = 1; i_addr = 32'h30;
      exp_cmd(base + 1, 1'b0, 32'h30, 32'h0);
      for (int k = 0; k < 5; k++) begin
         if (k == 2) begin
            i_flush = 1;
            i_req = 0;
         end
         if (k == 3) i_flush = 0;
         @(negedge clk);
         chk("t4_i_done", {31'b0, i_done}, 0);
         if (k == 4) chk("t4_state_idle", 32'(dut.state), 32'(IDLE));
         next_cyc();
      end

      // external write, then read it back through the MEM port
      base = cyc;
      x_req = 1; x_we = 1; x_addr = 32'h100; x_wdata = 32'h55;
      exp_cmd(base + 1, 1'b1, 32'h100, 32'h55);
      exp_done(base + 3, 3, 32'h0, 1'b0);
      exp_cmd(base + 5, 1'b0, 32'h100, 32'h0);
      exp_done(base + 7, 1, 32'h55, 1'b1);
      for (int k = 0; k < 8; k++) begin
         if (k == 4) begin
            d_req = 1; d_we = 0; d_addr = 32'h100;
         end
         @(negedge clk);
         if (k == 2) begin
            chk("t6_we_held", {31'b0, mem_we}, 1);
            chk("t6_addr_held", mem_addr, 32'h100);
         end
         if (x_done) begin
            x_req = 0;
            x_we = 0;
         end
         if (d_done) d_req = 0;
         next_cyc();
      end

      // asynchronous reset in the middle of an access
      base = cyc;
      d_req = 1; d_we = 0; d_addr = 32'h80;
      exp_cmd(base + 1, 1'b0, 32'h80, 32'h0);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("t5_stall_pre", {31'b0, stall_mem}, 1);
         next_cyc();
      end
      #1;
      rst_n = 1'b0;
      #1;
      chk("t5_mem_en", {31'b0, mem_en}, 0);
      chk("t5_d_done", {31'b0, d_done}, 0);
      chk("t5_stall_mem", {31'b0, stall_mem}, 0);
      chk("t5_stall_if", {31'b0, stall_if}, 0);
      chk("t5_mem_addr", mem_addr, 0);
      chk("t5_state", 32'(dut.state), 32'(IDLE));
      d_req = 0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("t5_quiet_mem_en", {31'b0, mem_en}, 0);
      end

      @(negedge clk);
      chk("cmd_q_drained", cmd_q.size(), 0);
      chk("done_q_drained", done_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
